// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped countdown timer: FSM encoding,
// register offsets, CTRL bit positions and MODE codes.
package timer_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_CNT  = 2'd2;
    localparam logic [1:0] ST_INT  = 2'd3;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] ADDR_RSVD   = 2'd3;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_IM       = 3;
    localparam int CTRL_W        = 4;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

endpackage

// File: rtl/timer_prescaler.sv
// Tick generator: one-cycle pulse every PRESCALE cycles, restarted by clr.
module timer_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == CW'(PRESCALE - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/timer_counter.sv
// Memory-mapped countdown timer (CTRL/PRESET/COUNT) with one-shot and
// auto-reload modes and a level irq. Define TIMER_PRESCALE_EN to slow the count.
module timer_counter
    import timer_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int PRESCALE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [CNT_W-1:0]  preset_q, preset_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [1:0]        state_q, state_d;
    logic              pend_q, pend_d;
    logic              reload_q, reload_d;
    logic              irq_q, irq_d;
    logic              tick;
    logic              wr_ctrl;
    logic              wr_preset;

    if (PRESCALE < 2) begin : g_bad_prescale
        $error("timer_counter: PRESCALE must be >= 2");
    end

`ifdef TIMER_PRESCALE_EN
    timer_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (state_q == ST_LOAD),
        .tick  (tick)
    );
`else
    assign tick = 1'b1;
`endif

    assign wr_ctrl   = sel && we && (addr == ADDR_CTRL);
    assign wr_preset = sel && we && (addr == ADDR_PRESET);

    always_comb begin
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        state_d  = state_q;
        pend_d   = pend_q;
        reload_d = reload_q;

        if (wr_ctrl) begin
            ctrl_d = wdata[CTRL_W-1:0];
            pend_d = 1'b0;
        end
        if (wr_preset) begin
            preset_d = wdata[CNT_W-1:0];
            pend_d   = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (ctrl_q[CTRL_EN]) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                count_d  = preset_q;
                // A reload from INT keeps pend so a still-pending irq is not lost
                if (!reload_q) begin
                    pend_d = 1'b0;
                end
                reload_d = 1'b0;
                state_d  = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_q[CTRL_EN]) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    if (count_q <= CNT_W'(1)) begin
                        count_d = '0;
                        state_d = ST_INT;
                    end else begin
                        count_d = count_q - CNT_W'(1);
                    end
                end
            end
            default: begin
                pend_d = 1'b1;
                if (ctrl_q[CTRL_MODE_LSB +: 2] == MODE_RELOAD) begin
                    reload_d = 1'b1;
                    state_d  = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                    // A same-cycle CPU write to CTRL decides EN
                    if (!wr_ctrl) begin
                        ctrl_d[CTRL_EN] = 1'b0;
                    end
                end
            end
        endcase

        irq_d = ctrl_q[CTRL_IM] & pend_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            state_q  <= ST_IDLE;
            pend_q   <= 1'b0;
            reload_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            state_q  <= state_d;
            pend_q   <= pend_d;
            reload_q <= reload_d;
            irq_q    <= irq_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            ADDR_CTRL:   rdata = 32'(ctrl_q);
            ADDR_PRESET: rdata = 32'(preset_q);
            ADDR_COUNT:  rdata = 32'(count_q);
            default:     rdata = '0;
        endcase
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter; inputs change and outputs are sampled on
// the falling edge, the design acts on the rising edge.
module tb_timer_counter;

    logic        clk;
    logic        reset;
    logic        sel;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int n_checks;
    int n_fails;

    timer_counter #(
        .CNT_W    (32),
        .PRESCALE (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sel   (sel),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        sel   = 1'b1;
        we    = 1'b1;
        addr  = a;
        wdata = d;
        @(negedge clk);
        sel   = 1'b0;
        we    = 1'b0;
        wdata = '0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [31:0] v;
    logic [31:0] exp_cnt [9] = '{2, 1, 0, 0, 2, 1, 0, 0, 2};
    logic        exp_irq [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 1};

    initial begin
        n_checks = 0;
        n_fails  = 0;
        reset = 1'b1;
        sel   = 1'b0;
        we    = 1'b0;
        addr  = 2'd0;
        wdata = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

`ifndef TIMER_PRESCALE_EN
        // Reset asserted while COUNT=5 mid-count
        bus_write(2'd1, 32'd10);
        bus_write(2'd0, 32'h9);
        repeat (6) @(negedge clk);
        rd(2'd2, v); check("pre_reset_count", v, 32'd6);
        @(negedge clk);
        rd(2'd2, v); check("pre_reset_count5", v, 32'd5);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        rd(2'd0, v); check("rst_ctrl", v, 32'd0);
        rd(2'd1, v); check("rst_preset", v, 32'd0);
        rd(2'd2, v); check("rst_count", v, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        repeat (3) @(negedge clk);
        rd(2'd2, v); check("rst_count_idle", v, 32'd0);

        // One-shot, PRESET=3
        do_reset();
        bus_write(2'd1, 32'd3);
        bus_write(2'd0, 32'h9);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            rd(2'd2, v); check($sformatf("oneshot_count%0d", k), v, 32'(3 - k));
        end
        check("oneshot_irq_int", 32'(irq), 32'd0);
        @(negedge clk);
        rd(2'd0, v); check("oneshot_ctrl", v, 32'h8);
        check("oneshot_irq_pend", 32'(irq), 32'd0);
        @(negedge clk);
        check("oneshot_irq_high", 32'(irq), 32'd1);
        bus_write(2'd0, 32'h8);
        check("oneshot_irq_lag", 32'(irq), 32'd1);
        @(negedge clk);
        check("oneshot_irq_fall", 32'(irq), 32'd0);

        // Auto-reload, PRESET=2, period 4
        do_reset();
        bus_write(2'd1, 32'd2);
        bus_write(2'd0, 32'hB);
        @(negedge clk);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            rd(2'd2, v); check($sformatf("reload_count%0d", k), v, exp_cnt[k]);
            check($sformatf("reload_irq%0d", k), 32'(irq), 32'(exp_irq[k]));
        end
        bus_write(2'd1, 32'd5);
        @(negedge clk);
        check("reload_preset_drop_irq", 32'(irq), 32'd0);

        // Masked interrupt
        do_reset();
        bus_write(2'd1, 32'd1);
        bus_write(2'd0, 32'h1);
        repeat (6) @(negedge clk);
        rd(2'd0, v); check("mask_ctrl", v, 32'h0);
        check("mask_irq", 32'(irq), 32'd0);
        bus_write(2'd0, 32'h8);
        check("mask_irq_w0", 32'(irq), 32'd0);
        @(negedge clk);
        check("mask_irq_w1", 32'(irq), 32'd0);

        // CTRL write colliding with INT, then ignored writes
        do_reset();
        bus_write(2'd1, 32'd2);
        bus_write(2'd0, 32'h9);
        repeat (3) @(negedge clk);
        bus_write(2'd0, 32'h9);
        rd(2'd0, v); check("coll_ctrl_en_kept", v, 32'h9);
        @(negedge clk);
        check("coll_pend_won", 32'(irq), 32'd1);
        @(negedge clk);
        rd(2'd2, v); check("coll_restart_count", v, 32'd2);
        @(negedge clk);
        check("coll_load_clears_pend", 32'(irq), 32'd0);
        bus_write(2'd2, 32'h55);
        rd(2'd2, v); check("count_write_ignored", v, 32'd0);
        bus_write(2'd3, 32'hFFFF_FFFF);
        rd(2'd3, v); check("rsvd_reads_zero", v, 32'd0);
        rd(2'd0, v); check("rsvd_write_no_ctrl", v, 32'h8);

        // PRESET=0 expires like PRESET=1
        do_reset();
        bus_write(2'd0, 32'h9);
        repeat (4) @(negedge clk);
        rd(2'd0, v); check("preset0_ctrl", v, 32'h8);
`else
        // Prescaled count, PRESET=2, PRESCALE=4
        rd(2'd0, v); check("rst_ctrl", v, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        bus_write(2'd1, 32'd2);
        bus_write(2'd0, 32'h9);
        @(negedge clk);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            rd(2'd2, v);
            check($sformatf("presc_count%0d", k), v, (k < 4) ? 32'd2 : (k < 8) ? 32'd1 : 32'd0);
        end
        rd(2'd0, v); check("presc_ctrl_int", v, 32'h9);
        @(negedge clk);
        rd(2'd0, v); check("presc_ctrl_done", v, 32'h8);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/timer_counter.md
Name: timer_counter

Overview:
- Memory-mapped countdown timer on the CPU data bus.
- The CPU is the bus initiator (loads/stores via the bridge); this block is the responder.
- Three word registers: CTRL, PRESET, COUNT.
- Raises a level interrupt `irq` to the CPU when a countdown expires; supports one-shot and auto-reload modes.

Parameters:
- CNT_W, 32, width of PRESET/COUNT; bits above CNT_W-1 read 0 and are ignored on write.
- PRESCALE, 4, cycles per decrement; used only when TIMER_PRESCALE_EN is defined; must be >= 2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- sel  in  1  bridge selects this device this cycle
- we  in  1  write strobe; qualified by sel
- addr  in  2  word offset: 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved
- wdata  in  32  store data
- rdata  out  32  combinational read of the register at addr, independent of sel and we
- irq  out  1  interrupt request, level, registered

Behaviour:
- Synchronous, active-high reset: CTRL=0, PRESET=0, COUNT=0, pend=0, state=IDLE, irq=0. Reset wins over everything, including a same-cycle write or a mid-count state.
- CTRL bits:
  - [0] EN
  - [2:1] MODE: 00 one-shot, 01 auto-reload, 1x treated as 00
  - [3] IM, interrupt mask, 1 = enabled
  - [31:4] read 0
- Writes (sel & we): take effect at the clock edge.
  - A write to CTRL or PRESET also clears pend.
  - Writes to COUNT and to addr 3 are ignored; addr 3 reads 0.
- irq = IM & pend, registered; it reflects CTRL/pend the cycle after they change.
- FSM:
  - IDLE: if EN=1, go to LOAD.
  - LOAD: COUNT<=PRESET, pend<=0; go to CNT.
  - CNT:
    - if EN=0, go to IDLE with COUNT frozen;
    - else if COUNT<=1, COUNT<=0 and go to INT;
    - else COUNT<=COUNT-1.
  - INT: pend<=1.
    - MODE 00: EN<=0, go to IDLE.
    - MODE 01: go to LOAD.
- Latency: with PRESET=N>=1 and EN set by a write at edge t0:
  - LOAD at t0+1;
  - COUNT=N visible after t0+2;
  - INT state N cycles after LOAD;
  - irq high one cycle after pend sets.
  - PRESET=0 behaves like PRESET=1.
- Simultaneous events:
  - A CPU write to CTRL in the INT cycle overrides the FSM's EN clear (the written EN wins).
  - A CPU write clearing pend in the INT cycle loses: pend=1.
- A PRESET write mid-count does not disturb COUNT; the new value takes effect at the next LOAD.
- Clearing EN mid-count: IDLE next cycle. Re-setting EN restarts from PRESET via LOAD.
- Auto-reload with pend still set: pend stays 1 through LOAD (only a CPU write clears it).
  - This overrides the LOAD rule above when re-entering from INT.
  - LOAD clears pend only when entered from IDLE.

Optional Feature:
- Macro: TIMER_PRESCALE_EN.
- Defined: CNT decrements only on a tick pulse, asserted once every PRESCALE cycles.
  - The tick counter resets to 0 on reset and on LOAD.
  - The COUNT<=1 expiry check is also tick-gated.
- Undefined: decrement every cycle in CNT; the PRESCALE parameter is unused.

Decomposition:
- Shared package timer_pkg:
  - state encoding (IDLE, LOAD, CNT, INT);
  - register offsets;
  - CTRL bit indices;
  - MODE codes.
- One sub-module, timer_prescaler: tick generator with clk, reset, clr, tick; instantiated only under TIMER_PRESCALE_EN.

Test Plan:
- Reset mid-count, asserted with COUNT=5 → next cycle all registers 0, state IDLE, irq=0; rdata at addr 0/1/2 = 0.
- One-shot: write PRESET=3, then CTRL=0x9 (EN, IM, mode 00) → COUNT reads 3,2,1,0; irq rises 1 cycle after INT; CTRL reads 0x8. Write CTRL=0x8 → irq falls next cycle.
- Auto-reload: PRESET=2, CTRL=0xB → irq stays high; COUNT cycles 2,1,0 repeatedly with period 4 cycles (LOAD, 2× CNT, INT). A PRESET write drops irq.
- Mask: PRESET=1, CTRL=0x1 → pend set, irq stays 0; then write CTRL=0x8 → pend cleared by the write, irq stays 0.
- Collision: in the INT cycle of one-shot, CPU writes CTRL=0x9 → EN remains 1, FSM re-enters LOAD via IDLE. Write to COUNT=0x55 is ignored; addr 3 reads 0.
- TIMER_PRESCALE_EN, PRESCALE=4, PRESET=2 → each COUNT value holds 4 cycles; INT reached 8 cycles after LOAD.
